// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-port bundle: requester side (master) and arbiter side (slave).
interface fb_write_arbiter_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [9*NREQ-1:0] req_x;
  logic [8*NREQ-1:0] req_y;
  logic [NREQ-1:0]   req_bit;
  logic [NREQ-1:0]   gnt;
  logic              pause;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic              do_write;
  logic [8:0]        write_x;
  logic [7:0]        write_y;
  logic              write;

  modport master (
    output req, req_x, req_y, req_bit, pause, clear_start,
    input  gnt, clear_busy, clear_done, do_write, write_x, write_y, write
  );

  modport slave (
    input  req, req_x, req_y, req_bit, pause, clear_start,
    output gnt, clear_busy, clear_done, do_write, write_x, write_y, write
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin burst arbiter for the single framebuffer write port, with a built-in
// full-screen clear sequencer. All outputs are registered.
module fb_write_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned FB_W      = 320,
  parameter int unsigned FB_H      = 200
) (
  input logic               clk,
  input logic               rst,
  fb_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StClear} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      rr_q, rr_d;
  logic [8:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [8:0]      cx_q, cx_d;
  logic [7:0]      cy_q, cy_d;
  logic            dw_q, dw_d;
  logic [8:0]      wx_q, wx_d;
  logic [7:0]      wy_q, wy_d;
  logic            wb_q, wb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            pick_vld;
  logic [1:0]      pick_idx;
  logic [1:0]      own_idx;
  logic [8:0]      own_x;
  logic [7:0]      own_y;
  logic            own_bit;
  logic            beat;

  // Descending scan so the lowest offset from the rr pointer wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (bus.req[(int'(rr_q) + k) % int'(NREQ)]) begin
        pick_vld = 1'b1;
        pick_idx = 2'((int'(rr_q) + k) % int'(NREQ));
      end
    end
  end

  always_comb begin
    own_idx = '0;
    own_x   = '0;
    own_y   = '0;
    own_bit = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_q[i]) begin
        own_idx = 2'(i);
        own_x   = bus.req_x[9*i +: 9];
        own_y   = bus.req_y[8*i +: 8];
        own_bit = bus.req_bit[i];
      end
    end
  end

  assign beat = |(gnt_q & bus.req);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dw_d    = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wb_d    = wb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // A clear request arriving during a sweep is absorbed by that sweep.
    if (bus.clear_start && (state_q != StClear)) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (!bus.pause) begin
          if (pend_q || bus.clear_start) begin
            state_d = StClear;
            busy_d  = 1'b1;
            cx_d    = '0;
            cy_d    = '0;
          end else if (pick_vld) begin
            state_d         = StGrant;
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            cnt_d           = '0;
          end
        end
      end

      StGrant: begin
        if (beat) begin
          dw_d  = 1'b1;
          wx_d  = own_x;
          wy_d  = own_y;
          wb_d  = own_bit;
          cnt_d = cnt_q + 9'd1;
        end
        if (!beat || (cnt_q == 9'(MAX_BURST - 1))) begin
          state_d = StIdle;
          gnt_d   = '0;
          rr_d    = (own_idx == 2'(NREQ - 1)) ? 2'd0 : own_idx + 2'd1;
        end
      end

      StClear: begin
        if (!bus.pause) begin
          dw_d = 1'b1;
          wx_d = cx_q;
          wy_d = cy_q;
          wb_d = 1'b0;
          if (cx_q == 9'(FB_W - 1)) begin
            cx_d = '0;
            if (cy_q == 8'(FB_H - 1)) begin
              cy_d    = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pend_d  = 1'b0;
              state_d = StIdle;
            end else begin
              cy_d = cy_q + 8'd1;
            end
          end else begin
            cx_d = cx_q + 9'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      dw_q    <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      wb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dw_q    <= dw_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wb_q    <= wb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.do_write   = dw_q;
  assign bus.write_x    = wx_q;
  assign bus.write_y    = wy_q;
  assign bus.write      = wb_q;
  assign bus.clear_busy = busy_q;
  assign bus.clear_done = done_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: table-driven burst vectors, directed clear/pause/reset
// sequences, and random traffic compared against a transaction-level reference model.
module tb_fb_write_arbiter;

  localparam int NREQ = 3;
  localparam int MAXB = 256;
  localparam int W    = 8;
  localparam int H    = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fb_write_arbiter_if #(.NREQ(NREQ)) bus ();

  fb_write_arbiter #(
    .NREQ     (NREQ),
    .MAX_BURST(MAXB),
    .FB_W     (W),
    .FB_H     (H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Reference model: mode 0 idle, 1 granted, 2 clearing; clear position as a linear pixel index.
  int         m_mode, m_owner, m_beats, m_pix, m_rr;
  bit         m_pend;
  logic [2:0] e_gnt;
  logic       e_dw, e_bit, e_busy, e_done;
  logic [8:0] e_x;
  logic [7:0] e_y;

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_beats = 0; m_pix = 0; m_rr = 0; m_pend = 0;
    e_gnt = '0; e_dw = 0; e_bit = 0; e_busy = 0; e_done = 0; e_x = '0; e_y = '0;
  endtask

  task automatic model_step();
    bit found;
    e_dw   = 0;
    e_done = 0;
    if (bus.clear_start && m_mode != 2) m_pend = 1;
    case (m_mode)
      0: if (!bus.pause) begin
        if (m_pend) begin
          m_mode = 2; m_pix = 0; e_busy = 1;
        end else if (bus.req != 0) begin
          found = 0;
          for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req[(m_rr + k) % NREQ]) begin
              found = 1; m_owner = (m_rr + k) % NREQ;
            end
          end
          e_gnt = 3'b001 << m_owner; m_beats = 0; m_mode = 1;
        end
      end
      1: begin
        if (bus.req[m_owner]) begin
          e_dw  = 1;
          e_x   = bus.req_x[9*m_owner +: 9];
          e_y   = bus.req_y[8*m_owner +: 8];
          e_bit = bus.req_bit[m_owner];
          m_beats++;
        end
        if (!bus.req[m_owner] || m_beats == MAXB) begin
          e_gnt = '0; m_rr = (m_owner + 1) % NREQ; m_mode = 0;
        end
      end
      default: if (!bus.pause) begin
        e_dw = 1; e_x = 9'(m_pix % W); e_y = 8'(m_pix / W); e_bit = 0;
        m_pix++;
        if (m_pix == W * H) begin
          e_busy = 0; e_done = 1; m_pend = 0; m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    bit ok;
    model_step();
    @(posedge clk);
    #1;
    ok = (bus.gnt === e_gnt) && (bus.do_write === e_dw) && (bus.clear_busy === e_busy) &&
         (bus.clear_done === e_done);
    if (e_dw) ok = ok && (bus.write_x === e_x) && (bus.write_y === e_y) && (bus.write === e_bit);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model t=%0t got gnt=%b dw=%b x=%0d y=%0d w=%b busy=%b done=%b; expected gnt=%b dw=%b x=%0d y=%0d w=%b busy=%b done=%b",
               $time, bus.gnt, bus.do_write, bus.write_x, bus.write_y, bus.write, bus.clear_busy,
               bus.clear_done, e_gnt, e_dw, e_x, e_y, e_bit, e_busy, e_done);
    end
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_bit = '0;
    bus.pause = 0; bus.clear_start = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", int'(bus.gnt), 0);
    chk("reset_outs", int'({bus.do_write, bus.write_x, bus.write_y, bus.write,
                            bus.clear_busy, bus.clear_done}), 0);
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    logic [2:0] req;
    logic [8:0] x;
    logic [7:0] y;
    logic       b;
    logic [2:0] gnt;
    logic       dw;
    logic [8:0] ex;
    logic [7:0] ey;
    logic       eb;
  } vec_t;

  vec_t tv[8];

  initial begin
    int ndw, nw, nd, bad, lastx, lasty, gaps, pz_left, post_gnt;
    bit pz_started, seen_done, busy_gnt;
    errors = 0;
    checks = 0;

    tv[0] = '{3'b001, 9'd5,  8'd6, 1'b1, 3'b001, 1'b0, 9'd0,  8'd0, 1'b0};
    tv[1] = '{3'b001, 9'd11, 8'd2, 1'b1, 3'b001, 1'b1, 9'd11, 8'd2, 1'b1};
    tv[2] = '{3'b001, 9'd21, 8'd3, 1'b0, 3'b001, 1'b1, 9'd21, 8'd3, 1'b0};
    tv[3] = '{3'b001, 9'd31, 8'd4, 1'b1, 3'b001, 1'b1, 9'd31, 8'd4, 1'b1};
    tv[4] = '{3'b001, 9'd41, 8'd5, 1'b0, 3'b001, 1'b1, 9'd41, 8'd5, 1'b0};
    tv[5] = '{3'b001, 9'd51, 8'd6, 1'b1, 3'b001, 1'b1, 9'd51, 8'd6, 1'b1};
    tv[6] = '{3'b000, 9'd99, 8'd9, 1'b1, 3'b000, 1'b0, 9'd0,  8'd0, 1'b0};
    tv[7] = '{3'b000, 9'd0,  8'd0, 1'b0, 3'b000, 1'b0, 9'd0,  8'd0, 1'b0};

    // Single requester, five beats then drop.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.req     = tv[i].req;
      bus.req_x   = {18'd0, tv[i].x};
      bus.req_y   = {16'd0, tv[i].y};
      bus.req_bit = {2'b00, tv[i].b};
      tick();
      chk($sformatf("tv%0d_gnt", i), int'(bus.gnt), int'(tv[i].gnt));
      chk($sformatf("tv%0d_dw", i), int'(bus.do_write), int'(tv[i].dw));
      if (tv[i].dw)
        chk($sformatf("tv%0d_pix", i), int'({bus.write_x, bus.write_y, bus.write}),
            int'({tv[i].ex, tv[i].ey, tv[i].eb}));
    end

    // All three requesting: full bursts in rotation with one idle cycle between.
    do_reset();
    ndw = 0;
    bus.req = 3'b111;
    for (int e = 1; e <= 780; e++) begin
      bus.req_x   = 27'($urandom);
      bus.req_y   = 24'($urandom);
      bus.req_bit = 3'($urandom);
      tick();
      if (e >= 2 && e <= 257 && bus.do_write) ndw++;
      case (e)
        1, 256:   chk($sformatf("rr_gnt_e%0d", e), int'(bus.gnt), 1);
        257, 514: chk($sformatf("rr_gap_e%0d", e), int'(bus.gnt), 0);
        258:      chk("rr_gnt_e258", int'(bus.gnt), 2);
        515:      chk("rr_gnt_e515", int'(bus.gnt), 4);
        771:      chk("rr_gap_e771", int'(bus.gnt), 0);
        772:      chk("rr_gnt_e772", int'(bus.gnt), 1);
        default: ;
      endcase
    end
    chk("burst_beats", ndw, MAXB);

    // Clear from idle.
    do_reset();
    bus.clear_start = 1;
    tick();
    bus.clear_start = 0;
    chk("clr_busy_start", int'(bus.clear_busy), 1);
    nw = 0; nd = 0; bad = 0; lastx = -1; lasty = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.do_write) begin
        nw++; lastx = int'(bus.write_x); lasty = int'(bus.write_y);
        if (bus.write !== 1'b0) bad++;
      end
      if (bus.clear_done) nd++;
    end
    chk("clr_writes", nw, W * H);
    chk("clr_last_x", lastx, W - 1);
    chk("clr_last_y", lasty, H - 1);
    chk("clr_done_pulses", nd, 1);
    chk("clr_nonzero", bad, 0);
    chk("clr_busy_end", int'(bus.clear_busy), 0);

    // Clear requested mid-burst: burst finishes, clear runs, then rr resumes at requester 1.
    do_reset();
    bus.req = 3'b011;
    repeat (4) tick();
    bus.clear_start = 1;
    tick();
    bus.clear_start = 0;
    chk("mid_gnt_kept", int'(bus.gnt), 1);
    repeat (2) tick();
    bus.req = 3'b010;
    tick();
    bus.req = 3'b011;
    seen_done = 0; busy_gnt = 0; post_gnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.clear_busy && bus.gnt != 0) busy_gnt = 1;
      if (bus.clear_done) seen_done = 1;
      if (seen_done && post_gnt == 0 && bus.gnt != 0) post_gnt = int'(bus.gnt);
    end
    chk("mid_clear_done", int'(seen_done), 1);
    chk("mid_gnt_in_clear", int'(busy_gnt), 0);
    chk("mid_next_gnt", post_gnt, 2);

    // Pause for three cycles at pixel 10.
    do_reset();
    bus.clear_start = 1;
    tick();
    bus.clear_start = 0;
    nw = 0; bad = 0; gaps = 0; pz_left = 0; pz_started = 0;
    for (int i = 0; i < 50; i++) begin
      bus.pause = (pz_left > 0);
      tick();
      if (pz_left > 0) pz_left--;
      if (bus.do_write) begin
        if (int'(bus.write_y) * W + int'(bus.write_x) != nw) bad++;
        nw++;
      end else if (nw > 0 && nw < W * H) begin
        gaps++;
      end
      if (nw == 10 && !pz_started) begin
        pz_started = 1; pz_left = 3;
      end
    end
    bus.pause = 0;
    chk("pause_order", bad, 0);
    chk("pause_gaps", gaps, 3);
    chk("pause_writes", nw, W * H);

    // Asynchronous reset in the middle of a sweep.
    do_reset();
    bus.clear_start = 1;
    tick();
    bus.clear_start = 0;
    repeat (5) tick();
    #2;
    rst = 1;
    #1;
    chk("arst_gnt", int'(bus.gnt), 0);
    chk("arst_outs", int'({bus.do_write, bus.write_x, bus.write_y, bus.write,
                           bus.clear_busy, bus.clear_done}), 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    nd = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.clear_done) nd++;
      if (bus.clear_busy || bus.do_write) bad++;
    end
    chk("arst_no_done", nd, 0);
    chk("arst_quiet", bad, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NREQ; b++) if ($urandom_range(7) == 0) bus.req[b] = ~bus.req[b];
      bus.req_x       = 27'($urandom);
      bus.req_y       = 24'($urandom);
      bus.req_bit     = 3'($urandom);
      bus.pause       = ($urandom_range(9) == 0);
      bus.clear_start = ($urandom_range(99) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
